// File: rtl/gpr_write_arbiter.sv
// Arbitrates the single GPR write port between the load unit (always wins) and the ALU (queued on loss).
// Writes are registered: one cycle minimum latency; ALU is back-pressured via alu_ready when the FIFO is full.
module gpr_write_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  input  logic [DW-1:0]            ld_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_addr,
  input  logic [DW-1:0]            alu_data,
  output logic                     gpr_we,
  output logic [AW-1:0]            gpr_ws,
  output logic [DW-1:0]            gpr_wdata,
  input  logic [AW-1:0]            chk_addr,
  output logic                     chk_hit,
  output logic [$clog2(DEPTH):0]   pend_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  logic          alu_acc;
  logic          ld_issue;
  logic          fifo_ne;
  logic          pop;
  logic          bypass;
  logic          push;
  logic          issue;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_data;
  logic          q_hit;

  assign pend_cnt  = cnt;
  // Ready looks only at the registered count, so a same-cycle pop never raises it.
  assign alu_ready = rst && (cnt < CW'(DEPTH));
  assign alu_acc   = alu_valid && alu_ready;
  assign ld_issue  = ld_valid && (ld_addr != '0);
  assign fifo_ne   = (cnt != '0);
  assign pop       = !ld_issue && fifo_ne;
  assign bypass    = !ld_issue && !fifo_ne && alu_acc && (alu_addr != '0);
  assign push      = alu_acc && (alu_addr != '0) && !bypass;
  assign issue     = ld_issue || pop || bypass;

  always_comb begin
    iss_addr = ld_addr;
    iss_data = ld_data;
    if (!ld_issue) begin
      if (fifo_ne) begin
        iss_addr = q_addr[rd_ptr];
        iss_data = q_data[rd_ptr];
      end else begin
        iss_addr = alu_addr;
        iss_data = alu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gpr_we    <= 1'b0;
      gpr_ws    <= '0;
      gpr_wdata <= '0;
    end else begin
      gpr_we <= issue;
      if (issue) begin
        gpr_ws    <= iss_addr;
        gpr_wdata <= iss_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= alu_addr;
      q_data[wr_ptr] <= alu_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; full/empty come from cnt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(PW'(PW'(i) - rd_ptr)) < cnt) && (q_addr[i] == chk_addr)) begin
        q_hit = 1'b1;
      end
    end
  end

  assign chk_hit = (chk_addr != '0) && ((gpr_we && (gpr_ws == chk_addr)) || q_hit);

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Directed and constrained-random bench for gpr_write_arbiter with a write-order scoreboard.
module tb_gpr_write_arbiter;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        gpr_we;
  logic [4:0]  gpr_ws;
  logic [31:0] gpr_wdata;
  logic [4:0]  chk_addr;
  logic        chk_hit;
  logic [1:0]  pend_cnt;

  int n_vec;
  int n_err;

  logic [31:0] model_rf [32];
  logic [31:0] obs_rf   [32];
  logic [4:0]  aq_addr  [$];
  logic [31:0] aq_data  [$];

  int          bp_rdy [7] = '{1, 1, 0, 0, 0, 1, 1};
  int          bp_cnt [7] = '{1, 2, 2, 2, 1, 1, 0};
  logic [4:0]  bp_ws  [7] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd7, 5'd8, 5'd9};
  logic [31:0] bp_wd  [7] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h70, 32'h71, 32'h72};
  logic [4:0]  bp_alu [3] = '{5'd7, 5'd8, 5'd9};

  gpr_write_arbiter #(.DW(32), .AW(5), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .gpr_we    (gpr_we),
    .gpr_ws    (gpr_ws),
    .gpr_wdata (gpr_wdata),
    .chk_addr  (chk_addr),
    .chk_hit   (chk_hit),
    .pend_cnt  (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
  endtask

  // Scoreboard for one registered write, given what the load unit drove the previous cycle.
  task automatic observe(input logic pl_v, input logic [4:0] pl_a, input logic [31:0] pl_d);
    if (gpr_we) begin
      chk("ws_nonzero", 64'(gpr_ws != 5'd0), 64'd1);
      obs_rf[gpr_ws] = gpr_wdata;
    end
    if (pl_v && pl_a != 5'd0) begin
      chk("rnd_ld", {gpr_we, gpr_ws, gpr_wdata}, {1'b1, pl_a, pl_d});
    end else if (gpr_we) begin
      if (aq_addr.size() == 0) begin
        chk("rnd_spurious_we", 64'(gpr_we), 64'd0);
      end else begin
        chk("rnd_alu_order", {gpr_ws, gpr_wdata}, {aq_addr[0], aq_data[0]});
        void'(aq_addr.pop_front());
        void'(aq_data.pop_front());
      end
    end
  endtask

  initial begin
    logic        acc;
    logic        pl_v;
    logic [4:0]  pl_a;
    logic [31:0] pl_d;
    int          idx;

    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    chk_addr = '0;
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      obs_rf[i]   = '0;
    end

    // Reset state
    step();
    step();
    chk("rst_we", 64'(gpr_we), 64'd0);
    chk("rst_ws", 64'(gpr_ws), 64'd0);
    chk("rst_wdata", 64'(gpr_wdata), 64'd0);
    chk("rst_cnt", 64'(pend_cnt), 64'd0);
    chk("rst_rdy", 64'(alu_ready), 64'd0);
    rst = 1'b1;
    step();

    // Uncontended ALU bypass
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h12345678;
    #1;
    chk("unc_rdy", 64'(alu_ready), 64'd1);
    step();
    idle_inputs();
    chk_addr = 5'd5;
    #1;
    chk("unc_wr", {gpr_we, gpr_ws, gpr_wdata}, {1'b1, 5'd5, 32'h12345678});
    chk("unc_hit", 64'(chk_hit), 64'd1);
    chk("unc_cnt", 64'(pend_cnt), 64'd0);
    step();
    chk("unc_we_off", 64'(gpr_we), 64'd0);
    chk("unc_hold", {gpr_ws, gpr_wdata}, {5'd5, 32'h12345678});
    chk("unc_hit_off", 64'(chk_hit), 64'd0);

    // Contention: load wins, ALU queued one cycle
    ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'hAAAA0000;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h4444;
    step();
    idle_inputs();
    chk_addr = 5'd4;
    #1;
    chk("con_ld", {gpr_we, gpr_ws, gpr_wdata}, {1'b1, 5'd3, 32'hAAAA0000});
    chk("con_cnt1", 64'(pend_cnt), 64'd1);
    chk("con_qhit", 64'(chk_hit), 64'd1);
    step();
    chk("con_alu", {gpr_we, gpr_ws, gpr_wdata}, {1'b1, 5'd4, 32'h4444});
    chk("con_cnt0", 64'(pend_cnt), 64'd0);
    step();
    chk("con_idle", 64'(gpr_we), 64'd0);

    // Backpressure: four load cycles to r1 while the ALU offers r7, r8, r9
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      ld_valid  = (c < 4);
      ld_addr   = 5'd1;
      ld_data   = 32'h100 + 32'(c);
      alu_valid = (idx < 3);
      alu_addr  = (idx < 3) ? bp_alu[idx] : 5'd0;
      alu_data  = 32'h70 + 32'(idx);
      #1;
      chk("bp_rdy", 64'(alu_ready), 64'(bp_rdy[c]));
      acc = alu_valid && alu_ready;
      step();
      if (acc) idx++;
      chk("bp_wr", {gpr_we, gpr_ws, gpr_wdata}, {1'b1, bp_ws[c], bp_wd[c]});
      chk("bp_cnt", 64'(pend_cnt), 64'(bp_cnt[c]));
    end
    idle_inputs();
    step();

    // r0 filter: load to r0 does not block the ALU bypass
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'hDEADBEEF;
    alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h66;
    chk_addr = 5'd0;
    #1;
    chk("r0_hit", 64'(chk_hit), 64'd0);
    step();
    idle_inputs();
    chk("r0_byp", {gpr_we, gpr_ws, gpr_wdata}, {1'b1, 5'd6, 32'h66});
    chk("r0_cnt", 64'(pend_cnt), 64'd0);
    step();
    chk("r0_nowr", 64'(gpr_we), 64'd0);

    // Reset with two queued entries
    ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 32'h22;
    alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA0;
    step();
    alu_addr = 5'd11; alu_data = 32'hB0;
    step();
    chk("rb_full", 64'(pend_cnt), 64'd2);
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("rb_rdy", 64'(alu_ready), 64'd0);
    step();
    chk("rb_we", 64'(gpr_we), 64'd0);
    chk("rb_cnt", 64'(pend_cnt), 64'd0);
    chk("rb_ws", 64'(gpr_ws), 64'd0);
    rst = 1'b1;
    chk_addr = 5'd10;
    #1;
    chk("rb_hit", 64'(chk_hit), 64'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rb_stale", 64'(gpr_we), 64'd0);
    end

    // Random traffic: loads to r0..r15, ALU to r0 or r16..r31
    pl_v = 1'b0; pl_a = '0; pl_d = '0;
    for (int c = 0; c < 400; c++) begin
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
      ld_data  = $urandom;
      if (!alu_valid) begin
        alu_valid = ($urandom_range(0, 9) < 6);
        alu_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
        alu_data  = $urandom;
      end
      chk_addr = 5'($urandom_range(0, 31));
      #1;
      acc = alu_valid && alu_ready;
      if (acc && alu_addr != 5'd0) begin
        aq_addr.push_back(alu_addr);
        aq_data.push_back(alu_data);
        model_rf[alu_addr] = alu_data;
      end
      if (ld_valid && ld_addr != 5'd0) model_rf[ld_addr] = ld_data;
      pl_v = ld_valid; pl_a = ld_addr; pl_d = ld_data;
      step();
      if (acc) alu_valid = 1'b0;
      observe(pl_v, pl_a, pl_d);
    end
    ld_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      acc = alu_valid && alu_ready;
      if (acc && alu_addr != 5'd0) begin
        aq_addr.push_back(alu_addr);
        aq_data.push_back(alu_data);
        model_rf[alu_addr] = alu_data;
      end
      step();
      if (acc) alu_valid = 1'b0;
      observe(1'b0, 5'd0, 32'd0);
    end
    chk("rnd_drained", 64'(aq_addr.size()), 64'd0);
    chk("rnd_cnt", 64'(pend_cnt), 64'd0);
    for (int r = 0; r < 32; r++) begin
      chk("rnd_rf", {27'(r), obs_rf[r]}, {27'(r), model_rf[r]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_write_arbiter.md
Name: gpr_write_arbiter

Overview:
- Shares the single write port of the 32x32 general-purpose register file between two writeback sources: the load unit and the ALU.
- The load unit always wins and is never back-pressured.
- ALU results that lose arbitration wait in a small in-order FIFO; the ALU is stalled through a ready signal when the FIFO is full.
- A combinational lookup reports whether a register has a write still in flight, so the hazard logic can stall a dependent read.

Parameters:
- DW, 32, data width.
- AW, 5, register address width.
- DEPTH, 2, ALU holding FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- ld_valid  in  1  load writeback request; the load unit never waits.
- ld_addr  in  AW  load destination register.
- ld_data  in  DW  load writeback data.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle when alu_valid && alu_ready.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU writeback data.
- gpr_we  out  1  register-file write enable (registered).
- gpr_ws  out  AW  register-file write select (registered).
- gpr_wdata  out  DW  register-file write data (registered).
- chk_addr  in  AW  hazard query address.
- chk_hit  out  1  a write to chk_addr is pending (combinational).
- pend_cnt  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0 at a clock edge):
  - gpr_we=0, gpr_ws=0, gpr_wdata=0, FIFO emptied, pend_cnt=0.
  - Any queued ALU results are discarded.
  - alu_ready=0 while rst=0.
- alu_ready = rst && (pend_cnt < DEPTH), computed from registered count only. A pop in the same cycle does not raise ready.
- Register 0 filter:
  - A request to address 0 is an accepted no-op.
  - A load to r0 asserts no write and does not block the FIFO or ALU for that cycle.
  - An ALU request to r0 is accepted (if ready) and neither pushed nor issued.
- Issue selection each cycle, in priority order; the selected write is registered onto gpr_* for exactly one cycle:
  1. ld_valid && ld_addr!=0 -> issue load.
  2. FIFO not empty -> pop head and issue it.
  3. ALU accepted && alu_addr!=0 && FIFO empty -> bypass, issue ALU directly.
  4. Otherwise gpr_we=0. gpr_ws and gpr_wdata hold their last value.
- Push rule: an accepted ALU request with addr!=0 that is not bypassed is pushed at the FIFO tail.
  - Simultaneous push and pop is allowed; occupancy is unchanged.
- Ordering:
  - ALU results reach the register file in acceptance order; there is no bypass while the FIFO is non-empty.
  - Load-versus-ALU ordering to the same register is not guaranteed here. Hazard logic uses chk_hit to prevent it.
- Latency:
  - Uncontended ALU or load: gpr_we asserts the cycle after the request.
  - A queued entry issues k cycles later, where k = number of consecutive load-priority cycles plus its position in the FIFO.
- chk_hit = 1 when chk_addr!=0 and either:
  - (gpr_we && gpr_ws==chk_addr), or
  - any valid FIFO entry has that address.
  - chk_addr=0 always gives 0.
- Write timing: the register file captures on the falling clock edge, so gpr_* are stable half a cycle before capture. No combinational path exists from inputs to gpr_*.
- FIFO pointers wrap modulo DEPTH. Full/empty are derived from pend_cnt, not from pointer equality.
- Reset during a queued burst: on release the FIFO is empty and no stale write issues.

Test Plan:
- Uncontended ALU: alu_valid=1, addr=5, data=0x12345678 for 1 cycle, no load -> next cycle gpr_we=1, ws=5, wdata=0x12345678; chk_hit(5)=1 during that cycle; pend_cnt stays 0.
- Contention: load (r3, 0xAAAA0000) and ALU (r4, 0x4444) in the same cycle -> r3 written first, r4 the following cycle; pend_cnt goes 1 then 0.
- Backpressure:
  - Setup: loads held valid to r1 for 4 cycles while the ALU sends r7, r8, r9.
  - Required: r7 and r8 queued, alu_ready=0 from the third cycle, r9 held by the ALU.
  - After the loads end: writes r7, r8, r9 in order, one per cycle.
- r0 filter: load to r0 together with ALU to r6 -> r6 issues next cycle via bypass; no write to r0 ever; chk_hit(0)=0.
- Reset mid-burst: FIFO holding 2 entries, rst=0 for 1 cycle -> gpr_we=0, pend_cnt=0, alu_ready=0 during reset; no queued write appears after release.
- Randomized load/ALU traffic against a reference model -> final register contents match, ALU order is preserved, gpr_we never asserts with ws=0.
